mem_stage: RTL and testbench

Memory-access stage of the five-stage in-order pipeline. It sits between EXE and WB, consumes the data-SRAM read response for loads, extracts and extends sub-word load data, and drives the `mem_wb_valid` / `wb_allowin` handshake and the 102-bit `mem_wb_bus` that WB consumes. It can stall on a late `data_sram_data_ok` and buffers the response when WB back-pressures.

---
 rtl/mem_stage.sv | 172 +++++++++++++++++
 tb/tb_mem_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE and WB.
// Latches the EXE bus, waits for the data-SRAM response of any instruction
// that issued a request, extracts and extends sub-word load data, and
// presents the result to WB via mem_wb_valid / mem_wb_bus.
// Optional feature macro: MEM_FWD_EN. When defined, mem_id_bus carries the
// forwarding information for ID. When undefined, mem_id_bus is tied to zero
// and ID relies on the WB interlock.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | no response owed, or response arriving this cycle
// WAIT  | request issued, data_ok not yet seen; instruction stalls in MEM
// HOLD  | response captured in hold_q while WB back-pressures
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         exe_mem_valid,
  output logic         mem_allowin,
  input  logic [106:0] exe_mem_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [101:0] mem_wb_bus,
  output logic [38:0]  mem_id_bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic [106:0]  bus_q, bus_d;
  logic [31:0]   hold_q, hold_d;

  logic          res_from_mem;
  logic [2:0]    ld_op;
  logic          gr_we;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic [31:0]   alu_result;
  logic [4:0]    dest;
  logic          req_issued;

  logic          needs_resp;
  logic          in_hold;
  logic          resp_ok;
  logic          mem_ready_go;
  logic [31:0]   load_src;
  logic [31:0]   load_shifted;
  logic [31:0]   load_data;
  logic [31:0]   final_result;

  // Unpack the latched EXE bus
  always_comb begin
    {res_from_mem, ld_op, gr_we, pc, inst, alu_result, dest, req_issued} = bus_q;
  end

  // Handshake: a response is owed only by instructions that issued a request;
  // data_ok is not consumed while a captured response is already held.
  always_comb begin
    needs_resp   = mem_valid_q & req_issued;
    in_hold      = (state_q == ST_HOLD);
    resp_ok      = data_sram_data_ok & ~in_hold;
    mem_ready_go = ~needs_resp | resp_ok | in_hold;
    mem_wb_valid = mem_valid_q & mem_ready_go;
    mem_allowin  = ~mem_valid_q | (mem_ready_go & wb_allowin);
  end

  // Input register next-state: bus sampled only on accept
  always_comb begin
    mem_valid_d = mem_valid_q;
    bus_d       = bus_q;
    if (mem_allowin) begin
      mem_valid_d = exe_mem_valid;
    end
    if (exe_mem_valid & mem_allowin) begin
      bus_d = exe_mem_bus;
    end
  end

  // Response FSM next-state and response capture
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_RUN: begin
        if (needs_resp) begin
          if (!data_sram_data_ok) begin
            state_d = ST_WAIT;
          end else if (!wb_allowin) begin
            state_d = ST_HOLD;
            hold_d  = data_sram_rdata;
          end
        end
      end
      ST_WAIT: begin
        if (data_sram_data_ok) begin
          if (wb_allowin) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
            hold_d  = data_sram_rdata;
          end
        end
      end
      ST_HOLD: begin
        if (wb_allowin) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      mem_valid_q <= 1'b0;
      bus_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      bus_q       <= bus_d;
      hold_q      <= hold_d;
    end
  end

  // Load alignment and extension; ld.w also covers unassigned ld_op codes
  always_comb begin
    load_src     = in_hold ? hold_q : data_sram_rdata;
    load_shifted = load_src >> {alu_result[1:0], 3'b000};
    case (ld_op)
      3'b001:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b010:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_data = {24'b0, load_shifted[7:0]};
      3'b110:  load_data = {16'b0, load_shifted[15:0]};
      default: load_data = load_shifted;
    endcase
    final_result = res_from_mem ? load_data : alu_result;
  end

  // Bus to WB; WB does the registering
  always_comb begin
    mem_wb_bus = {gr_we, pc, inst, final_result, dest};
  end

`ifdef MEM_FWD_EN
  logic fwd_we;
  logic load_pending;

  // Forwarding to ID, with a flag telling ID the load result is not yet valid
  always_comb begin
    fwd_we       = mem_valid_q & gr_we;
    load_pending = mem_valid_q & res_from_mem & ~mem_ready_go;
    mem_id_bus   = {fwd_we, dest, final_result, load_pending};
  end
`else
  // No forwarding path in this build
  always_comb begin
    mem_id_bus = 39'b0;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes the expected WB bus for each
// instruction, a monitor pops and compares on every WB transfer.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         exe_mem_valid = 1'b0;
  logic         mem_allowin;
  logic [106:0] exe_mem_bus = '0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         mem_wb_valid;
  logic         wb_allowin = 1'b1;
  logic [101:0] mem_wb_bus;
  logic [38:0]  mem_id_bus;

`ifdef MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [101:0] exp_q[$];

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .exe_mem_valid     (exe_mem_valid),
    .mem_allowin       (mem_allowin),
    .exe_mem_bus       (exe_mem_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_wb_valid      (mem_wb_valid),
    .wb_allowin        (wb_allowin),
    .mem_wb_bus        (mem_wb_bus),
    .mem_id_bus        (mem_id_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [106:0] mk(input logic rfm, input logic [2:0] op, input logic we,
                                      input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [31:0] alu, input logic [4:0] dest,
                                      input logic req);
    return {rfm, op, we, pc, inst, alu, dest, req};
  endfunction

  function automatic logic [101:0] wbx(input logic we, input logic [31:0] pc,
                                       input logic [31:0] inst, input logic [31:0] res,
                                       input logic [4:0] dest);
    return {we, pc, inst, res, dest};
  endfunction

  function automatic logic [38:0] idx(input logic we, input logic [4:0] dest,
                                      input logic [31:0] data, input logic lp);
`ifdef MEM_FWD_EN
    return {we, dest, data, lp};
`else
    return 39'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garble();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    exe_mem_bus = r[106:0];
  endtask

  // Monitor: every WB transfer must match the oldest expected entry
  always @(negedge clk) begin
    if (mem_wb_valid && wb_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got %h expected no transfer", mem_wb_bus);
      end else begin
        chk("wb_bus", 128'(mem_wb_bus), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 128'(mem_wb_valid), 128'(1'b0));
    chk("rst_allowin",  128'(mem_allowin),  128'(1'b1));
    chk("rst_wb_bus",   128'(mem_wb_bus),   128'(0));
    chk("rst_id_bus",   128'(mem_id_bus),   128'(0));
    tick();
    resetn = 1'b1;

    // ALU op
    tick();
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b0, 3'b000, 1'b1, 32'h1c00_0000, 32'h0280_0001, 32'h1234_5678, 5'd5, 1'b0);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0000, 32'h0280_0001, 32'h1234_5678, 5'd5));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    @(negedge clk);
    chk("alu_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("alu_id_bus",   128'(mem_id_bus),   128'(idx(1'b1, 5'd5, 32'h1234_5678, 1'b0)));

    // ld.b @..03 then ld.hu @..02 back-to-back, data_ok in first MEM cycle
    tick();
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b1, 3'b001, 1'b1, 32'h1c00_0004, 32'h2800_0002, 32'h0000_1003, 5'd7, 1'b1);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0004, 32'h2800_0002, 32'hFFFF_FF80, 5'd7));
    tick();
    exe_mem_bus = mk(1'b1, 3'b110, 1'b1, 32'h1c00_0008, 32'h2a40_0003, 32'h0000_2002, 5'd8, 1'b1);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0008, 32'h2a40_0003, 32'h0000_80AA, 5'd8));
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80AA_BBCC;
    @(negedge clk);
    chk("ldb_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("ldb_allowin",  128'(mem_allowin),  128'(1'b1));
    chk("ldb_id_bus",   128'(mem_id_bus),   128'(idx(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0)));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    @(negedge clk);
    chk("ldhu_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("ldhu_id_bus",   128'(mem_id_bus),   128'(idx(1'b1, 5'd8, 32'h0000_80AA, 1'b0)));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;

    // ld.w with data_ok three cycles late; bus changes while stalled
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b1, 3'b000, 1'b1, 32'h1c00_000c, 32'h2880_0004, 32'h0000_3000, 5'd9, 1'b1);
    exp_q.push_back(wbx(1'b1, 32'h1c00_000c, 32'h2880_0004, 32'hDEAD_BEEF, 5'd9));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    for (int i = 0; i < 3; i++) begin
      data_sram_rdata = $urandom();
      @(negedge clk);
      chk("wait_wb_valid", 128'(mem_wb_valid),  128'(1'b0));
      chk("wait_allowin",  128'(mem_allowin),   128'(1'b0));
      chk("wait_ld_pend",  128'(mem_id_bus[0]), 128'(FWD));
      tick();
      garble();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("late_id_bus",   128'(mem_id_bus),   128'(idx(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0)));
    tick();
    data_sram_data_ok = 1'b0;

    // ld.h: data_ok with WB stalled, then stray data_ok and garbage rdata
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b1, 3'b010, 1'b1, 32'h1c00_0010, 32'h2840_0005, 32'h0000_4000, 5'd10, 1'b1);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0010, 32'h2840_0005, 32'hFFFF_F00D, 5'd10));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_F00D;
    wb_allowin = 1'b0;
    @(negedge clk);
    chk("hold_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("hold_allowin",  128'(mem_allowin),  128'(1'b0));
    tick();
    data_sram_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("hold2_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("hold2_allowin",  128'(mem_allowin),  128'(1'b0));
    chk("hold2_id_bus",   128'(mem_id_bus),   128'(idx(1'b1, 5'd10, 32'hFFFF_F00D, 1'b0)));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = $urandom();
    wb_allowin = 1'b1;
    @(negedge clk);
    chk("hold3_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    tick();

    // ld.bu @..01: late data_ok while WB stalled (WAIT -> HOLD)
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b1, 3'b101, 1'b1, 32'h1c00_0014, 32'h2a00_0006, 32'h0000_5001, 5'd11, 1'b1);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0014, 32'h2a00_0006, 32'h0000_00F0, 5'd11));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    @(negedge clk);
    chk("w2h_stall", 128'(mem_wb_valid), 128'(1'b0));
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0000_F000;
    wb_allowin = 1'b0;
    @(negedge clk);
    chk("w2h_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    chk("w2h_allowin",  128'(mem_allowin),  128'(1'b0));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("w2h_id_bus", 128'(mem_id_bus), 128'(idx(1'b1, 5'd11, 32'h0000_00F0, 1'b0)));
    tick();
    wb_allowin = 1'b1;
    @(negedge clk);
    chk("w2h_release", 128'(mem_wb_valid), 128'(1'b1));
    tick();

    // Store: response owed, result is the ALU address, no register write
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b0, 3'b000, 1'b0, 32'h1c00_0018, 32'h2980_0007, 32'h0000_6004, 5'd0, 1'b1);
    exp_q.push_back(wbx(1'b0, 32'h1c00_0018, 32'h2980_0007, 32'h0000_6004, 5'd0));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = $urandom();
    @(negedge clk);
    chk("st_id_bus", 128'(mem_id_bus), 128'(idx(1'b0, 5'd0, 32'h0000_6004, 1'b0)));
    tick();
    data_sram_data_ok = 1'b0;

    // Reset during WAIT, then a stray data_ok
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b1, 3'b000, 1'b1, 32'h1c00_001c, 32'h2880_0008, 32'h0000_7000, 5'd12, 1'b1);
    tick();
    exe_mem_valid = 1'b0;
    garble();
    @(negedge clk);
    chk("rw_stall", 128'(mem_wb_valid), 128'(1'b0));
    tick();
    resetn = 1'b0;
    @(negedge clk);
    chk("rw_rst_valid",   128'(mem_wb_valid), 128'(1'b0));
    chk("rw_rst_allowin", 128'(mem_allowin),  128'(1'b1));
    chk("rw_rst_wb_bus",  128'(mem_wb_bus),   128'(0));
    chk("rw_rst_id_bus",  128'(mem_id_bus),   128'(0));
    tick();
    resetn = 1'b1;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = $urandom();
    @(negedge clk);
    chk("rw_stray_valid",   128'(mem_wb_valid), 128'(1'b0));
    chk("rw_stray_allowin", 128'(mem_allowin),  128'(1'b1));
    tick();
    data_sram_data_ok = 1'b0;

    // ALU op after recovery
    exe_mem_valid = 1'b1;
    exe_mem_bus = mk(1'b0, 3'b000, 1'b1, 32'h1c00_0020, 32'h0280_0009, 32'hCAFE_F00D, 5'd31, 1'b0);
    exp_q.push_back(wbx(1'b1, 32'h1c00_0020, 32'h0280_0009, 32'hCAFE_F00D, 5'd31));
    tick();
    exe_mem_valid = 1'b0;
    garble();
    @(negedge clk);
    chk("post_wb_valid", 128'(mem_wb_valid), 128'(1'b1));
    repeat (3) tick();
    chk("drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
